calc_cu_param: RTL
==================

// Module: calc_cu_param
// PURPOSE
// - Parametrised control unit for the lab calculator datapath (register file, input/ALU write mux, ALU, output buffer).
// - Captures a command on go, optionally loads operands, runs single- or multi-cycle ALU ops, writes the result back, and handshakes completion.
// - Adds destination addressing, operand-load bypass, multi-cycle ALU handshake with timeout, and illegal-op error reporting.
// PARAMETERS
// - AW          2           register-file address width (2**AW registers)
// - OPW         3           ALU opcode width
// - NUM_OPS     6           legal opcodes are 0..NUM_OPS-1; others are illegal
// - SC_MASK     8'h0F       bit k=1: opcode k completes in one cycle (no alu_done wait)
// - TIMEOUT     15          max WAIT_ALU cycles before error (1..255)
// PORTS
// - clk         in   1    clock, rising edge
// - rst_n       in   1    asynchronous active-low reset
// - go          in   1    command request, level; sampled in IDLE
// - load_en     in   1    1: load in_a/in_b into src_a/src_b first; 0: use resident register contents
// - op          in   OPW  ALU opcode
// - src_a       in   AW   operand A register address
// - src_b       in   AW   operand B register address
// - dst         in   AW   result register address
// - alu_done    in   1    multi-cycle ALU finished (single-cycle pulse)
// - wsel        out  2    write-data mux: 0 in_a, 1 in_b, 2 ALU result, 3 unused
// - we          out  1    register-file write enable
// - wa          out  AW   write address
// - rea, reb    out  1    read enables, ports A/B
// - raa, rab    out  AW   read addresses, ports A/B
// - alu_op      out  OPW  opcode to ALU
// - alu_start   out  1    one-cycle ALU start pulse
// - out_en      out  1    output-buffer load enable
// - busy        out  1    high in every state except IDLE
// - done        out  1    one-cycle completion pulse
// - err         out  1    high while in ERR
// BEHAVIOUR
// - Reset (rst_n=0, async): state IDLE, command registers 0, timeout counter 0, every output 0.
// - All outputs decoded from registered state and latched command only (Moore); no input-to-output combinational path.
// - IDLE: go=1 -> latch op/src_a/src_b/dst/load_en same edge; illegal op -> ERR; load_en=1 -> LOADA; else EXEC.
// - LOADA: we=1, wa=src_a, wsel=0 -> LOADB.  LOADB: we=1, wa=src_b, wsel=1 -> EXEC.
// - EXEC: rea=reb=1, raa=src_a, rab=src_b, alu_op=op, alu_start=1; SC_MASK[op] -> WRITE else WAIT_ALU (counter cleared).
// - WAIT_ALU: rea/reb/raa/rab/alu_op held; alu_done=1 -> WRITE; else counter+1; counter==TIMEOUT-1 without alu_done -> ERR.
// - WRITE: we=1, wa=dst, wsel=2, alu_op held -> DONE.  dst==src_a or src_b is legal (overwrite after use).
// - DONE: out_en=1, done=1 for exactly this one cycle -> HOLD.
// - HOLD: wait for go=0 -> IDLE (go held high never retriggers a command).
// - ERR: err=1, no writes; go=0 -> IDLE.
// - Inputs other than go/alu_done ignored outside IDLE; mid-command changes have no effect.
// - alu_done outside WAIT_ALU ignored; alu_done in the same cycle the counter expires wins (-> WRITE).
// - Latency go->done: load_en=1 single-cycle op = 5 cycles (IDLE,LOADA,LOADB,EXEC,WRITE then DONE); load_en=0 = 3.
// - rst_n asserted mid-command: immediate IDLE, pending write discarded; no done pulse.
// STRUCTURE
// - Shared package calc_pkg: state enum (IDLE,LOADA,LOADB,EXEC,WAIT_ALU,WRITE,DONE,HOLD,ERR), wsel constants (WSEL_A/B/ALU), opcode constants (ADD,SUB,AND,XOR,MUL,DIV).
// - One sub-module: calc_cu_timer (loadable down-counter, clear/enable/expired) for the WAIT_ALU timeout.
// - Single 3-bit... no: state register 4 bits; one sequential block for state/command/counter, one combinational output decode.
// TESTING
// - Reset: rst_n=0 with go=1 -> all outputs 0, state IDLE; release, go still 1 -> command starts next edge.
// - ADD, load_en=1, src_a=1, src_b=2, dst=3: we at wa=1,2 then 3 with wsel 0,1,2; done pulse 5 cycles after go edge.
// - load_en=0, op=AND, dst=src_a=0: no LOADA/LOADB writes; EXEC then WRITE wa=0; done after 3 cycles.
// - MUL (SC_MASK bit 4=0), alu_done after 4 wait cycles -> WRITE next cycle; busy high throughout; exactly one done.
// - MUL, alu_done never -> err=1 after TIMEOUT wait cycles, no dst write; go=0 -> IDLE, err=0.
// - op=7 (illegal) -> ERR directly from IDLE, no writes; go held high in HOLD/ERR never restarts; rst_n mid-WAIT_ALU -> IDLE, no done.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator control unit and its bench.
package calc_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StLoadA,
    StLoadB,
    StExec,
    StWaitAlu,
    StWrite,
    StDone,
    StHold,
    StErr
  } state_e;

  localparam logic [1:0] WselA   = 2'd0;
  localparam logic [1:0] WselB   = 2'd1;
  localparam logic [1:0] WselAlu = 2'd2;

  localparam logic [2:0] OpAdd = 3'd0;
  localparam logic [2:0] OpSub = 3'd1;
  localparam logic [2:0] OpAnd = 3'd2;
  localparam logic [2:0] OpXor = 3'd3;
  localparam logic [2:0] OpMul = 3'd4;
  localparam logic [2:0] OpDiv = 3'd5;

endpackage

// File: rtl/calc_cu_timer.sv
// Loadable down-counter bounding how long the control unit waits on a multi-cycle ALU op.
module calc_cu_timer #(
  parameter int unsigned CW      = 8,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [CW-1:0] LoadVal = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = LoadVal;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/calc_cu_param.sv
// Calculator control unit: latches a command, optionally loads operands, runs the ALU,
// writes the result back and handshakes completion. Outputs are decoded from state only.
module calc_cu_param
  import calc_pkg::*;
#(
  parameter int unsigned          AW      = 2,
  parameter int unsigned          OPW     = 3,
  parameter int unsigned          NUM_OPS = 6,
  parameter logic [(1<<OPW)-1:0]  SC_MASK = 8'h0F,
  parameter int unsigned          TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           go,
  input  logic           load_en,
  input  logic [OPW-1:0] op,
  input  logic [AW-1:0]  src_a,
  input  logic [AW-1:0]  src_b,
  input  logic [AW-1:0]  dst,
  input  logic           alu_done,
  output logic [1:0]     wsel,
  output logic           we,
  output logic [AW-1:0]  wa,
  output logic           rea,
  output logic           reb,
  output logic [AW-1:0]  raa,
  output logic [AW-1:0]  rab,
  output logic [OPW-1:0] alu_op,
  output logic           alu_start,
  output logic           out_en,
  output logic           busy,
  output logic           done,
  output logic           err
);

  state_e         state_q, state_d;
  logic [OPW-1:0] op_q, op_d;
  logic [AW-1:0]  src_a_q, src_a_d, src_b_q, src_b_d, dst_q, dst_d;
  logic           load_en_q, load_en_d;
  logic           tmr_clr, tmr_en, tmr_expired;

  assign tmr_clr = (state_q == StExec);
  assign tmr_en  = (state_q == StWaitAlu) && !alu_done;

  calc_cu_timer #(
    .CW      (8),
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (tmr_expired)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    src_a_d   = src_a_q;
    src_b_d   = src_b_q;
    dst_d     = dst_q;
    load_en_d = load_en_q;
    unique case (state_q)
      StIdle: begin
        if (go) begin
          op_d      = op;
          src_a_d   = src_a;
          src_b_d   = src_b;
          dst_d     = dst;
          load_en_d = load_en;
          if (32'(op) >= NUM_OPS) begin
            state_d = StErr;
          end else if (load_en) begin
            state_d = StLoadA;
          end else begin
            state_d = StExec;
          end
        end
      end
      StLoadA:   state_d = StLoadB;
      StLoadB:   state_d = StExec;
      StExec:    state_d = SC_MASK[op_q] ? StWrite : StWaitAlu;
      // alu_done takes priority over an expiring timer in the same cycle
      StWaitAlu: begin
        if (alu_done) begin
          state_d = StWrite;
        end else if (tmr_expired) begin
          state_d = StErr;
        end
      end
      StWrite:   state_d = StDone;
      StDone:    state_d = StHold;
      StHold, StErr: begin
        if (!go) begin
          state_d = StIdle;
        end
      end
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      op_q      <= '0;
      src_a_q   <= '0;
      src_b_q   <= '0;
      dst_q     <= '0;
      load_en_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      src_a_q   <= src_a_d;
      src_b_q   <= src_b_d;
      dst_q     <= dst_d;
      load_en_q <= load_en_d;
    end
  end

  always_comb begin
    wsel      = WselA;
    we        = 1'b0;
    wa        = '0;
    rea       = 1'b0;
    reb       = 1'b0;
    raa       = '0;
    rab       = '0;
    alu_op    = '0;
    alu_start = 1'b0;
    out_en    = 1'b0;
    busy      = (state_q != StIdle);
    done      = 1'b0;
    err       = 1'b0;
    case (state_q)
      StLoadA: begin
        we   = 1'b1;
        wa   = src_a_q;
        wsel = WselA;
      end
      StLoadB: begin
        we   = 1'b1;
        wa   = src_b_q;
        wsel = WselB;
      end
      StExec, StWaitAlu: begin
        rea       = 1'b1;
        reb       = 1'b1;
        raa       = src_a_q;
        rab       = src_b_q;
        alu_op    = op_q;
        alu_start = (state_q == StExec);
      end
      StWrite: begin
        we     = 1'b1;
        wa     = dst_q;
        wsel   = WselAlu;
        alu_op = op_q;
      end
      StDone: begin
        out_en = 1'b1;
        done   = 1'b1;
      end
      StErr:   err = 1'b1;
      default: ;
    endcase
  end

endmodule
